// File: rtl/cordic_pkg.sv
//==============================================================================
// Module      : cordic_pkg
// Description : Shared widths, default pipe latency and the tagged result record
//               used by the CORDIC arbiter and its result FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cordic_pkg;

    localparam int XW              = 20;
    localparam int ZW              = 23;
    localparam int LATENCY_DEFAULT = 16;
    localparam int IDW_MAX         = 3;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [XW-1:0]      x;
        logic [XW-1:0]      y;
    } result_t;

    localparam int RESW = $bits(result_t);

endpackage

`default_nettype wire

// File: rtl/cordic_result_fifo.sv
//==============================================================================
// Module      : cordic_result_fifo
// Description : Show-ahead result FIFO with occupancy count; the head output
//               holds the last popped record while the FIFO is empty.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr,
    input  logic [RESW-1:0] i_data,
    input  logic            i_pop,
    output logic            o_valid,
    output logic [RESW-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    result_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    result_t        r_last;

    logic           w_pop;
    logic           w_full;
    logic           w_wr;

    assign o_valid = (r_count != '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & o_valid;
    // A write into a full FIFO is only accepted when a pop frees the slot.
    assign w_wr    = i_wr & (~w_full | w_pop);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= result_t'(i_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cordic_rotate_arbiter.sv
//==============================================================================
// Module      : cordic_rotate_arbiter
// Description : Shares one fixed-latency CORDIC between NREQ requesters with
//               credit-controlled, ID-tagged, in-order result return.
//               Define CORDIC_ARB_STRICT_PRIO_EN for fixed lowest-index priority
//               instead of round-robin.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cordic_rotate_arbiter
    import cordic_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int LATENCY    = LATENCY_DEFAULT,
    parameter int FIFO_DEPTH = 32
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic [NREQ-1:0]    ireq_valid,
    input  logic [NREQ*XW-1:0] ireq_x,
    input  logic [NREQ*XW-1:0] ireq_y,
    input  logic [NREQ*ZW-1:0] ireq_z,
    output logic [NREQ-1:0]    oreq_ready,
    output logic               ocordic_nCS,
    output logic               ocordic_valid,
    output logic [XW-1:0]      ocordic_x,
    output logic [XW-1:0]      ocordic_y,
    output logic [ZW-1:0]      ocordic_z,
    input  logic               icordic_valid,
    input  logic [XW-1:0]      icordic_x,
    input  logic [XW-1:0]      icordic_y,
    output logic               ovalid,
    output logic [IDW-1:0]     oid,
    output logic [XW-1:0]      ox,
    output logic [XW-1:0]      oy,
    input  logic               iready,
    output logic               osync_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(LATENCY + 1);

    logic                        r_ncs;
    logic                        r_cvalid;
    logic [XW-1:0]               r_cx;
    logic [XW-1:0]               r_cy;
    logic [ZW-1:0]               r_cz;
    logic [IDW-1:0]              r_issue_id;
    logic [LATENCY-1:0]          r_tag_v;
    logic [LATENCY-1:0][IDW-1:0] r_tag_id;
    logic [CW-1:0]               r_credit;
    logic [DW-1:0]               r_drain;
    logic                        r_sync_err;
`ifndef CORDIC_ARB_STRICT_PRIO_EN
    logic [IDW-1:0]              r_ptr;
`endif

    logic [NREQ-1:0]             w_grant;
    logic                        w_found;
    logic                        w_can_grant;
    logic [IDW-1:0]              w_gnt_idx;
    logic [XW-1:0]               w_sel_x;
    logic [XW-1:0]               w_sel_y;
    logic [ZW-1:0]               w_sel_z;
    logic                        w_tail_v;
    logic                        w_fifo_wr;
    logic                        w_mismatch;
    logic                        w_restore;
    logic                        w_pop;
    result_t                     w_wdata;
    result_t                     w_head;
    logic [RESW-1:0]             w_head_bits;
    logic                        w_unused_id;

    assign w_can_grant = ~ireset & (r_credit != '0);

    always_comb begin
        int j;
        j         = 0;
        w_grant   = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sel_x   = '0;
        w_sel_y   = '0;
        w_sel_z   = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef CORDIC_ARB_STRICT_PRIO_EN
            j = k;
`else
            // Search starts one past the last granted requester and wraps.
            j = (int'(r_ptr) + 1 + k) % NREQ;
`endif
            if (w_can_grant && !w_found && ireq_valid[j]) begin
                w_found    = 1'b1;
                w_grant[j] = 1'b1;
                w_gnt_idx  = IDW'(j);
                w_sel_x    = ireq_x[j*XW +: XW];
                w_sel_y    = ireq_y[j*XW +: XW];
                w_sel_z    = ireq_z[j*ZW +: ZW];
            end
        end
    end

    assign w_tail_v   = r_tag_v[LATENCY-1];
    assign w_fifo_wr  = icordic_valid & w_tail_v;
    assign w_mismatch = icordic_valid ^ w_tail_v;
    // A tagged beat the CORDIC never delivered gives its FIFO slot back.
    assign w_restore  = w_tail_v & ~icordic_valid;
    assign w_pop      = ovalid & iready;

    always_comb begin
        w_wdata    = '0;
        w_wdata.id = IDW_MAX'(r_tag_id[LATENCY-1]);
        w_wdata.x  = icordic_x;
        w_wdata.y  = icordic_y;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_ncs      <= 1'b1;
            r_cvalid   <= 1'b0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_cz       <= '0;
            r_issue_id <= '0;
            r_tag_v    <= '0;
            r_tag_id   <= '0;
            r_credit   <= CW'(FIFO_DEPTH);
            r_drain    <= DW'(LATENCY);
            r_sync_err <= 1'b0;
`ifndef CORDIC_ARB_STRICT_PRIO_EN
            r_ptr      <= '0;
`endif
        end else begin
            r_ncs    <= 1'b0;
            r_cvalid <= w_found;
            if (w_found) begin
                r_cx       <= w_sel_x;
                r_cy       <= w_sel_y;
                r_cz       <= w_sel_z;
                r_issue_id <= w_gnt_idx;
`ifndef CORDIC_ARB_STRICT_PRIO_EN
                r_ptr      <= w_gnt_idx;
`endif
            end
            r_tag_v  <= {r_tag_v[LATENCY-2:0], r_cvalid};
            r_tag_id <= {r_tag_id[LATENCY-2:0], r_issue_id};
            r_credit <= r_credit + CW'(w_pop) + CW'(w_restore) - CW'(w_found);
            // Beats still leaving the CORDIC from before reset land here unchecked.
            if (r_drain != '0) begin
                r_drain <= r_drain - 1'b1;
            end
            if (w_mismatch && (r_drain == '0)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    cordic_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (iclk),
        .rst     (ireset),
        .i_wr    (w_fifo_wr),
        .i_data  (w_wdata),
        .i_pop   (w_pop),
        .o_valid (ovalid),
        .o_data  (w_head_bits)
    );

    assign w_head        = result_t'(w_head_bits);
    assign w_unused_id   = ^w_head.id;

    assign oreq_ready    = w_grant;
    assign ocordic_nCS   = r_ncs;
    assign ocordic_valid = r_cvalid;
    assign ocordic_x     = r_cx;
    assign ocordic_y     = r_cy;
    assign ocordic_z     = r_cz;
    assign oid           = w_head.id[IDW-1:0];
    assign ox            = w_head.x;
    assign oy            = w_head.y;
    assign osync_err     = r_sync_err;

endmodule

`default_nettype wire
